// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Op codes, FSM state encoding and counter sizing used by mdu_ctrl and div_iter.
// No logic lives here; everything is constants and pure helper functions.
package mdu_pkg;

  localparam int MDU_WIDTH     = 32;
  localparam int MDU_DIV_ITERS = MDU_WIDTH;

  // Operation codes presented on the op port
  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIV_RUN = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Iteration counter width; never narrower than one bit
  function automatic int cnt_width(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  localparam int MDU_CNT_W = cnt_width(MDU_DIV_ITERS);

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Unsigned restoring divider core, one quotient bit per step.
// Latency: ITERS step cycles after start; done pulses during the final step.
// No backpressure: the owner gates progress with step and may abandon at any time.
module div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITERS = WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             last;

  // The dividend shifts out of the quotient register into the remainder one bit per step;
  // the extra top bit of diff is the borrow that says "divisor did not fit".
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign last   = (cnt_q == CNT_W'(ITERS - 1));
  assign done   = step && last;

  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Load operands on start, otherwise advance one restoring step per enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer driving the HI/LO register write port.
// Latency: mult/move/divide-by-zero write in the issue cycle; divide writes after 1+DIV_ITERS stalled cycles.
// Backpressure: asserts stall to freeze IF..EX while a divide runs; flush aborts with no write.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH     = MDU_WIDTH,
  parameter int DIV_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = cnt_width(DIV_ITERS);

  logic [1:0]         state_q;
  logic               neg_quo_q;
  logic               neg_rem_q;

  logic               is_div;
  logic               div_signed;
  logic               rt_zero;
  logic               issue_div;
  logic               div_step;
  logic               div_done;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  assign is_div     = (op == MDU_DIV) || (op == MDU_DIVU);
  assign div_signed = (op == MDU_DIV);
  assign rt_zero    = (rt_data == '0);
  assign issue_div  = (state_q == ST_IDLE) && valid && !flush && is_div && !rt_zero;
  assign div_step   = (state_q == ST_DIV_RUN) && !flush;
  assign busy       = (state_q != ST_IDLE);

  // Divides run on magnitudes; signs are re-applied when the result is written
  assign rs_neg = div_signed && rs_data[WIDTH-1];
  assign rt_neg = div_signed && rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? (~rs_data + WIDTH'(1)) : rs_data;
  assign rt_mag = rt_neg ? (~rt_data + WIDTH'(1)) : rt_data;

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  // 0x80000000 / -1 wraps naturally to quotient 0x80000000, remainder 0.
  assign quo_fix = neg_quo_q ? (~div_quo + WIDTH'(1)) : div_quo;
  assign rem_fix = neg_rem_q ? (~div_rem + WIDTH'(1)) : div_rem;

  // Full-width products: extend operands so the low 2*WIDTH bits are exact
  assign prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
  assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  div_iter #(
    .WIDTH (WIDTH),
    .ITERS (DIV_ITERS),
    .CNT_W (CNT_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (issue_div),
    .step      (div_step),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sequencer state; DONE always returns to IDLE so the stalled instruction cannot re-issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_div) begin
            state_q   <= ST_DIV_RUN;
            neg_quo_q <= rs_neg ^ rt_neg;
            neg_rem_q <= rs_neg;
          end
        end
        ST_DIV_RUN: begin
          if (div_done) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall and HI/LO write mux; flush suppresses both in every state
  always_comb begin
    stall   = 1'b0;
    hilo_we = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid && !flush) begin
          case (op)
            MDU_MULT: begin
              hilo_we      = 1'b1;
              {hi_o, lo_o} = prod_s;
            end
            MDU_MULTU: begin
              hilo_we      = 1'b1;
              {hi_o, lo_o} = prod_u;
            end
            MDU_MTHI: begin
              hilo_we = 1'b1;
              hi_o    = rs_data;
              lo_o    = lo_cur;
            end
            MDU_MTLO: begin
              hilo_we = 1'b1;
              hi_o    = hi_cur;
              lo_o    = rs_data;
            end
            MDU_DIV, MDU_DIVU: begin
              if (rt_zero) begin
                hilo_we = 1'b1;
                hi_o    = rs_data;
                lo_o    = '1;
              end else begin
                stall = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DIV_RUN: stall = !flush;
      ST_DONE: begin
        if (!flush) begin
          hilo_we = 1'b1;
          hi_o    = rem_fix;
          lo_o    = quo_fix;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios then randomized ops against an arithmetic model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [2:0]   op;
  logic         flush;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic [W-1:0] hi_cur;
  logic [W-1:0] lo_cur;
  logic         stall;
  logic         busy;
  logic         hilo_we;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int checks   = 0;
  int failures = 0;

  mdu_ctrl #(.WIDTH(W), .DIV_ITERS(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .op      (op),
    .flush   (flush),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_cur  (hi_cur),
    .lo_cur  (lo_cur),
    .stall   (stall),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one instruction: MIPS HI/LO semantics in plain 64-bit arithmetic
  task automatic model(input logic [2:0] o, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hc, input logic [31:0] lc,
                       output logic we, output logic [31:0] hi, output logic [31:0] lo, output int n);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    we = 1'b0; hi = '0; lo = '0; n = 0;
    if (v) begin
      case (o)
        MDU_MULT:  begin p = sa * sb; we = 1'b1; hi = p[63:32]; lo = p[31:0]; end
        MDU_MULTU: begin pu = ua * ub; we = 1'b1; hi = pu[63:32]; lo = pu[31:0]; end
        MDU_MTHI:  begin we = 1'b1; hi = a; lo = lc; end
        MDU_MTLO:  begin we = 1'b1; hi = hc; lo = a; end
        MDU_DIV: begin
          we = 1'b1;
          if (b == 0) begin hi = a; lo = '1; end
          else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; n = 1 + W; end
        end
        MDU_DIVU: begin
          we = 1'b1;
          if (b == 0) begin hi = a; lo = '1; end
          else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; n = 1 + W; end
        end
        default: ;
      endcase
    end
  endtask

  // Issue one instruction, hold it while stalled, then check the write and the idle cycle after
  task automatic run_op(input string tag, input logic [2:0] o, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hc, input logic [31:0] lc);
    logic        ew;
    logic [31:0] eh, el;
    int          en, n;
    model(o, v, a, b, hc, lc, ew, eh, el, en);
    valid = v; op = o; rs_data = a; rt_data = b; hi_cur = hc; lo_cur = lc; flush = 1'b0;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      cyc();
      #1;
    end
    chk({tag, ".stall_cycles"}, 64'(n), 64'(en));
    chk({tag, ".busy"}, 64'(busy), 64'(en != 0));
    chk({tag, ".we"}, 64'(hilo_we), 64'(ew));
    chk({tag, ".hi"}, 64'(hi_o), 64'(eh));
    chk({tag, ".lo"}, 64'(lo_o), 64'(el));
    cyc();
    valid = 1'b0; op = MDU_NONE;
    #1;
    chk({tag, ".after"}, {61'b0, hilo_we, busy, stall}, 64'd0);
  endtask

  initial begin
    int writes;
    logic [2:0]  ro;
    logic        rv;
    logic [31:0] ra, rb;

    rst = 1'b1; valid = 1'b0; op = MDU_NONE; flush = 1'b0;
    rs_data = '0; rt_data = '0; hi_cur = '0; lo_cur = '0;
    cyc();
    cyc();
    chk("reset.outs", {hilo_we, busy, stall, hi_o, lo_o}, 67'd0);
    rst = 1'b0;
    cyc();

    run_op("mult_neg", MDU_MULT, 1'b1, 32'hFFFFFFFD, 32'd5, 32'h1111, 32'h2222);
    run_op("div_neg7_2", MDU_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0);
    run_op("divu_big", MDU_DIVU, 1'b1, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0);
    run_op("div_by0", MDU_DIV, 1'b1, 32'h1234, 32'h0, 32'h0, 32'h0);
    run_op("divu_by0", MDU_DIVU, 1'b1, 32'hCAFE, 32'h0, 32'h0, 32'h0);
    run_op("div_ovf", MDU_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    run_op("div_7_neg2", MDU_DIV, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0);
    run_op("multu_max", MDU_MULTU, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    run_op("mthi", MDU_MTHI, 1'b1, 32'h600D, 32'h0, 32'hAAAA, 32'hBBBB);
    run_op("mtlo", MDU_MTLO, 1'b1, 32'h700D, 32'h0, 32'hCCCC, 32'hDDDD);
    run_op("none", MDU_NONE, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8);
    run_op("invalid", MDU_MULT, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8);

    // Flush on the tenth divide iteration, then an immediate MTHI
    valid = 1'b1; op = MDU_DIV; rs_data = 32'd100; rt_data = 32'd7;
    #1;
    chk("flush.issue_stall", 64'(stall), 64'd1);
    for (int i = 0; i < 10; i++) cyc();
    chk("flush.run_busy", {62'b0, busy, stall}, 64'd3);
    flush = 1'b1;
    #1;
    chk("flush.cycle", {62'b0, hilo_we, stall}, 64'd0);
    cyc();
    flush = 1'b0; op = MDU_MTHI; rs_data = 32'hABCD; lo_cur = 32'h5555;
    #1;
    chk("flush.mthi_busy", 64'(busy), 64'd0);
    chk("flush.mthi", {hilo_we, hi_o, lo_o}, {1'b1, 32'hABCD, 32'h5555});
    cyc();
    valid = 1'b0; op = MDU_NONE;

    // Reset in the middle of a divide: no write may ever appear for it
    cyc();
    valid = 1'b1; op = MDU_DIVU; rs_data = 32'd1000; rt_data = 32'd3;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1; valid = 1'b0; op = MDU_NONE;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid.outs", {hilo_we, busy, stall, hi_o, lo_o}, 67'd0);
    writes = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (hilo_we === 1'b1) writes++;
    end
    chk("rst_mid.no_write", 64'(writes), 64'd0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 6));
      rv = ($urandom_range(0, 7) != 0);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200));
      run_op("rand", ro, rv, ra, rb, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide sequencer in the EX stage of the MIPS pipeline.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO and stalls the pipeline while an iterative divide runs.
- Drives the write-enable and data inputs of the HI/LO register.
- Multiplies and moves complete in the issue cycle; divides take 32 iterations.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- DIV_ITERS, WIDTH, divider iterations, one quotient bit per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid  in  1  EX-stage instruction valid.
- op  in  3  operation code (mdu_pkg encoding).
- flush  in  1  exception/flush; aborts any operation.
- rs_data  in  WIDTH  dividend / multiplicand / MTHI/MTLO source.
- rt_data  in  WIDTH  divisor / multiplier.
- hi_cur  in  WIDTH  current HI value, for MTLO pass-through.
- lo_cur  in  WIDTH  current LO value, for MTHI pass-through.
- stall  out  1  holds IF..EX stages.
- busy  out  1  divide in progress (state != IDLE).
- hilo_we  out  1  HI/LO write enable.
- hi_o  out  WIDTH  HI write data.
- lo_o  out  WIDTH  LO write data.

Behaviour:
- Reset (sync, rst=1): state=IDLE, counter=0, operand/result registers=0. stall=0, busy=0, hilo_we=0, hi_o=0, lo_o=0 in the cycle after the reset edge. Reset mid-divide discards the operation with no write.
- States: IDLE, DIV_RUN, DONE.
- IDLE, valid=1, flush=0 (combinational outputs, same cycle, no state change unless stated):
  - MULT: {hi_o,lo_o} = signed 64-bit rs*rt; hilo_we=1.
  - MULTU: unsigned 64-bit rs*rt; hilo_we=1.
  - MTHI: hi_o=rs_data, lo_o=lo_cur, hilo_we=1.
  - MTLO: hi_o=hi_cur, lo_o=rs_data, hilo_we=1.
  - DIV/DIVU with rt_data != 0: latch |rs|, |rt| (or raw values for DIVU) and the two sign bits; counter=0; stall=1; next state DIV_RUN.
  - DIV/DIVU with rt_data == 0: no iteration, no stall. hilo_we=1, lo_o=all-ones, hi_o=rs_data.
  - NONE or valid=0: all outputs 0.
- DIV_RUN:
  - One restoring-division step per cycle: shift remainder left, subtract divisor, set quotient bit if the result is non-negative.
  - stall=1; counter increments; after iteration DIV_ITERS-1, next state DONE.
- DONE:
  - stall=0, hilo_we=1, lo_o=quotient, hi_o=remainder. Outputs are registered-source, not recomputed.
  - Signed fix-up: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - Next state IDLE unconditionally. The still-present valid/op (the same instruction held by the stall) must not restart a divide.
- Divide latency: issue cycle + 32 DIV_RUN cycles with stall=1 (33 stalled cycles); write in cycle 34.
- flush=1 in any state: hilo_we=0, stall=0 the same cycle; next state IDLE. flush has priority over a new issue and over DONE.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (natural wrap of the magnitude path).
- busy=1 in DIV_RUN and DONE.

Decomposition:
- mdu_pkg:
  - op codes MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - state encoding IDLE/DIV_RUN/DONE.
  - localparam for the counter width, $clog2(DIV_ITERS).
- Sub-module div_iter: unsigned iterative restoring divider core (start, operands, done, quotient, remainder).
- mdu_ctrl keeps decode, sign handling, FSM, the multiplier expression and the HI/LO output mux.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> same cycle hilo_we=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1, stall=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 held valid -> stall=1 for exactly 33 cycles; in cycle 34 hilo_we=1, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Next cycle hilo_we=0, no re-issue.
- DIVU rs=0xFFFFFFFF, rt=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F after 34 cycles.
- DIV rt=0, rs=0x1234 -> no stall; same cycle hilo_we=1, LO=0xFFFFFFFF, HI=0x1234.
- DIV started, flush=1 on DIV_RUN cycle 10 -> stall=0 and hilo_we=0 that cycle; state IDLE next; an immediately following MTHI rs=0xABCD writes HI=0xABCD, LO=lo_cur.
- Divide in flight, rst=1 for one cycle -> next cycle stall=0, busy=0, hilo_we=0, hi_o=lo_o=0. No write ever occurs for the aborted divide.
